// File: rtl/if_prefetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues sequential reads to
// the synchronous instruction memory, buffers returned words with their PCs
// in a small FIFO, and handles redirect (flush) and the sticky halt.
module if_prefetch_unit #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect,
   input  logic [PC_W-1:0]            redirect_pc,
   input  logic                       stall,
   input  logic                       halt,
   output logic                       imem_req,
   output logic [PC_W-1:0]            imem_addr,
   input  logic [INS_W-1:0]           imem_rdata,
   output logic                       instr_valid,
   output logic [INS_W-1:0]           instr,
   output logic [PC_W-1:0]            instr_pc,
   output logic                       halted,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);
   localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [0:0]       state;
   logic [PC_W-1:0]  fetch_pc;
   logic             inflight;
   logic [PC_W-1:0]  inflight_pc;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q;

   logic [INS_W-1:0] fifo_instr [DEPTH];
   logic [PC_W-1:0]  fifo_pc    [DEPTH];

   logic             run;
   logic [CNT_W:0]   occupancy;
   logic             issue;
   logic             push;
   logic             pop;

   // Handshake decode: issue gating, response push, head pop.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      run       = 1'b0;
      occupancy = '0;
      issue     = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;

      run       = (state == ST_RUN) && !reset;
      // A same-cycle pop deliberately does not free a slot for this issue.
      occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
      issue     = run && !redirect && (occupancy < DEPTH_OCC);
      // A response coinciding with a redirect is stale and is dropped.
      push      = run && !redirect && inflight;
      pop       = run && (count_q != '0) && !stall && !redirect;
   end

   // Output view: head entry is presented combinationally, zeroed when not valid.
   always_comb begin
      imem_req    = issue;
      imem_addr   = fetch_pc;
      instr_valid = run && (count_q != '0);
      instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
      instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;
      halted      = (state == ST_HALT);
      count       = count_q;
   end

   // Control state: fetch PC, in-flight tracking, FIFO pointers and RUN/HALT.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state       <= ST_RUN;
         fetch_pc    <= '0;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count_q     <= '0;
      end else if (state == ST_RUN) begin
         if (redirect) begin
            // Flush everything buffered or in flight; redirect also wins over halt.
            fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
         end else begin
            if (halt) begin
               state <= ST_HALT;
            end
            inflight <= issue;
            if (issue) begin
               fetch_pc    <= fetch_pc + PC_STEP;
               inflight_pc <= fetch_pc;
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
               count_q <= count_q + CNT_ONE;
            end else if (pop && !push) begin
               count_q <= count_q - CNT_ONE;
            end
         end
      end
   end

   // FIFO storage: data/PC words written on push.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; count and pointers alone decide which entries are meaningful.
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= inflight_pc;
      end
   end

   // Occupancy guards: issue gating and pop qualification must keep the FIFO in range.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(push && !pop && (count_q == CNT_W'(DEPTH))));
         assert (!(pop && (count_q == '0)));
      end
   end

endmodule
